pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Centralised hazard, forwarding and stall controller for the 5-stage MIPS pipeline. It replaces the separate forwarding and load-use hazard blocks and adds three capabilities: multi-cycle data-memory wait freezing, branch-operand hazards for ID-resolved branches, and a selectable branch resolution stage. It also provides saturating stall and flush performance counters. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers and drives their enables, flushes and bubbles, plus the ALU operand forwarding muxes.

Parameters:
REG_ADDR_W, 5, register index width
MEM_LATENCY, 1, data-memory access cycles (1 = single cycle, no freeze); legal range 1..15
RESOLVE_STAGE, 0, branch/jump resolution stage: 0 = ID, 1 = EX
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt
id_branch  in  1  ID instruction is beq/bne/jr (reads operands in ID)
ex_rs, ex_rt  in  REG_ADDR_W  source registers in EX
ex_reg_write, ex_mem_read  in  1  EX control
ex_write_reg  in  REG_ADDR_W  EX destination (after RegDst/jal mux)
mem_reg_write, mem_mem_read, mem_access  in  1  MEM control (mem_access = load or store)
mem_write_reg  in  REG_ADDR_W  MEM destination
wb_reg_write  in  1  WB control
wb_write_reg  in  REG_ADDR_W  WB destination
redirect  in  1  taken branch/jump/jr, resolved in RESOLVE_STAGE
pc_enable, if_id_enable  out  1  front-end hold when 0
if_id_flush, id_ex_bubble  out  1  squash IF/ID; zero ID/EX control
id_ex_enable, ex_mem_enable  out  1  freeze hold when 0
mem_wb_bubble  out  1  insert a WB bubble while the memory access is outstanding
forward_a, forward_b  out  2  10 = EX/MEM ALU result, 01 = WB write data, 00 = register file
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
Forwarding (combinational):
- forward_a = 10 if mem_reg_write, mem_write_reg != 0 and mem_write_reg == ex_rs.
- Otherwise forward_a = 01 if the same test passes on the wb_* signals.
- Otherwise forward_a = 00.
- forward_b uses the identical rules with ex_rt. EX/MEM always wins over WB. Register 0 is never forwarded.

Freeze FSM (states RUN, MEM_WAIT; 4-bit down-counter wcnt):
- RUN, mem_access=1 and MEM_LATENCY>1: freeze=1; next state MEM_WAIT with wcnt=MEM_LATENCY-2.
- MEM_WAIT with wcnt!=0: freeze=1 and wcnt decrements. With wcnt==0: freeze=0 and next state is RUN.
- Total freeze is exactly MEM_LATENCY-1 cycles per access. An access held in MEM never retriggers.
- While freeze=1: pc_enable, if_id_enable, id_ex_enable and ex_mem_enable are 0, and mem_wb_bubble=1.

Load-use stall (only when freeze=0):
- Condition: ex_mem_read, ex_write_reg != 0, and ex_write_reg == id_rs (or == id_rt with id_uses_rt).
- Response: pc_enable=0, if_id_enable=0, id_ex_bubble=1 for one cycle.

Branch-operand stall (RESOLVE_STAGE=0 and id_branch only):
- Stall the same way if ex_reg_write matches a used ID source.
- Also stall if mem_mem_read and mem_write_reg matches a used ID source.
- Register 0 is excluded from both tests.

Redirect (acted on only when freeze=0 and no stall):
- Always: if_id_flush=1.
- RESOLVE_STAGE=1: also id_ex_bubble=1.
- A redirect during a stall or freeze is ignored that cycle. ID/EX are held, so redirect re-presents and is taken once the stall or freeze clears.

Priority: freeze > stall > redirect.

Counters:
- stall_cnt increments on every cycle with freeze or a stall.
- flush_cnt increments on every acted-on redirect.
- Both saturate at all-ones.

Reset (synchronous, active-high):
- State RUN, wcnt=0, counters 0.
- Outputs then follow the combinational rules: with idle inputs, enables=1, flush/bubble=0, forward=00.
- Reset in MEM_WAIT aborts the freeze on the next edge.

Decomposition:
- Package pipe_ctrl_pkg holds: forward select constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10), the FSM state enum, and the RESOLVE_ID/RESOLVE_EX constants.
- One sub-module, hazard_match: a parametrised comparator returning "dst nonzero and equals a used source". It is instanced for load-use, branch-operand and both forwarding paths.

Test Plan:
1. Forwarding priority: mem_write_reg=wb_write_reg=ex_rs=8, both reg_write=1 -> forward_a=10. Drop mem_reg_write -> forward_a=01. Set all destinations to 0 -> forward_a=00.
2. Load-use: ex_mem_read=1, ex_write_reg=9, id_rt=9, id_uses_rt=1 -> one cycle of pc_enable=0, id_ex_bubble=1; stall_cnt=1. With id_uses_rt=0 -> no stall.
3. MEM_LATENCY=4: mem_access pulse -> freeze held exactly 3 cycles (enables 0, mem_wb_bubble=1), then RUN. MEM_LATENCY=1 -> no freeze ever.
4. Redirect with RESOLVE_STAGE=0 -> if_id_flush=1, id_ex_bubble=0, flush_cnt=1. With RESOLVE_STAGE=1 -> both asserted.
5. Simultaneous freeze, load-use and redirect: only freeze outputs are active. Redirect is taken on the first cycle after both freeze and stall clear.
6. Reset asserted on the second MEM_WAIT cycle -> RUN on the next edge with counters 0. Drive stall_cnt through 2^CNT_W+3 stall cycles with CNT_W=4 -> counter holds 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and types for the pipeline hazard controller.
//   fwd_sel_t / FWD_*   : ALU operand forwarding mux selects
//   frz_state_e         : data-memory freeze FSM states
//   RESOLVE_ID/EX       : branch resolution stage selectors
//   WCNT_W              : width of the freeze wait counter (MEM_LATENCY <= 15)
package pipe_ctrl_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } frz_state_e;

  localparam int unsigned RESOLVE_ID = 0;
  localparam int unsigned RESOLVE_EX = 1;

  localparam int unsigned WCNT_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-side signal bundle of the hazard controller.
//   Pipe-register control inputs (ID/EX/MEM/WB register indices and control
//   bits, redirect) and controller outputs (enables, flushes, bubbles,
//   forwarding selects, performance counters).
//   master : pipeline side (drives stage info, receives controls)
//   slave  : controller side
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);

  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  id_branch;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_write_reg;
  logic                  mem_reg_write;
  logic                  mem_mem_read;
  logic                  mem_access;
  logic [REG_ADDR_W-1:0] mem_write_reg;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_write_reg;
  logic                  redirect;

  logic                  pc_enable;
  logic                  if_id_enable;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic                  id_ex_enable;
  logic                  ex_mem_enable;
  logic                  mem_wb_bubble;
  logic [1:0]            forward_a;
  logic [1:0]            forward_b;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_branch,
    output ex_rs, ex_rt, ex_reg_write, ex_mem_read, ex_write_reg,
    output mem_reg_write, mem_mem_read, mem_access, mem_write_reg,
    output wb_reg_write, wb_write_reg, redirect,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_bubble,
    input  id_ex_enable, ex_mem_enable, mem_wb_bubble,
    input  forward_a, forward_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_branch,
    input  ex_rs, ex_rt, ex_reg_write, ex_mem_read, ex_write_reg,
    input  mem_reg_write, mem_mem_read, mem_access, mem_write_reg,
    input  wb_reg_write, wb_write_reg, redirect,
    output pc_enable, if_id_enable, if_id_flush, id_ex_bubble,
    output id_ex_enable, ex_mem_enable, mem_wb_bubble,
    output forward_a, forward_b, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// hazard_match: register dependency comparator.
//   en     : producer actually writes dst (reg_write / mem_read qualifier)
//   dst    : producer destination register
//   src_a/use_a, src_b/use_b : consumer source registers and their use flags
//   hit    : en, dst != 0, and dst equals a used source
module hazard_match #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] src_a,
  input  logic              use_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic              use_b,
  output logic              hit
);

  always_comb begin
    hit = en && (dst != '0) &&
          ((use_a && (dst == src_a)) || (use_b && (dst == src_b)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and stall controller for the 5-stage
// MIPS pipeline.
//   clk, reset : clock and synchronous active-high reset
//   bus        : pipe_hazard_ctrl_if.slave
//     inputs  : ID/EX/MEM/WB register indices and control bits, redirect
//     outputs : pc/if_id/id_ex/ex_mem enables, if_id_flush, id_ex_bubble,
//               mem_wb_bubble, forward_a/b, stall_cnt/flush_cnt
// Priority of pipeline actions: memory freeze > stall > redirect.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W    = 5,
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned RESOLVE_STAGE = RESOLVE_ID,
  parameter int unsigned CNT_W         = 16
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam bit MULTI_CYCLE = (MEM_LATENCY > 1);
  localparam logic [WCNT_W-1:0] WAIT_INIT =
    WCNT_W'(MULTI_CYCLE ? (MEM_LATENCY - 2) : 0);
  localparam bit BR_IN_ID = (RESOLVE_STAGE == RESOLVE_ID);

  // ---------------------------------------------------------------------------
  // Dependency comparators
  // ---------------------------------------------------------------------------
  logic fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb;
  logic load_use, br_ex_hit, br_mem_hit;

  hazard_match #(.ADDR_W(REG_ADDR_W)) u_fwd_a_mem (
    .en(bus.mem_reg_write), .dst(bus.mem_write_reg),
    .src_a(bus.ex_rs), .use_a(1'b1), .src_b('0), .use_b(1'b0),
    .hit(fwd_a_mem)
  );

  hazard_match #(.ADDR_W(REG_ADDR_W)) u_fwd_a_wb (
    .en(bus.wb_reg_write), .dst(bus.wb_write_reg),
    .src_a(bus.ex_rs), .use_a(1'b1), .src_b('0), .use_b(1'b0),
    .hit(fwd_a_wb)
  );

  hazard_match #(.ADDR_W(REG_ADDR_W)) u_fwd_b_mem (
    .en(bus.mem_reg_write), .dst(bus.mem_write_reg),
    .src_a(bus.ex_rt), .use_a(1'b1), .src_b('0), .use_b(1'b0),
    .hit(fwd_b_mem)
  );

  hazard_match #(.ADDR_W(REG_ADDR_W)) u_fwd_b_wb (
    .en(bus.wb_reg_write), .dst(bus.wb_write_reg),
    .src_a(bus.ex_rt), .use_a(1'b1), .src_b('0), .use_b(1'b0),
    .hit(fwd_b_wb)
  );

  hazard_match #(.ADDR_W(REG_ADDR_W)) u_load_use (
    .en(bus.ex_mem_read), .dst(bus.ex_write_reg),
    .src_a(bus.id_rs), .use_a(1'b1), .src_b(bus.id_rt), .use_b(bus.id_uses_rt),
    .hit(load_use)
  );

  hazard_match #(.ADDR_W(REG_ADDR_W)) u_br_ex (
    .en(bus.ex_reg_write), .dst(bus.ex_write_reg),
    .src_a(bus.id_rs), .use_a(1'b1), .src_b(bus.id_rt), .use_b(bus.id_uses_rt),
    .hit(br_ex_hit)
  );

  hazard_match #(.ADDR_W(REG_ADDR_W)) u_br_mem (
    .en(bus.mem_mem_read), .dst(bus.mem_write_reg),
    .src_a(bus.id_rs), .use_a(1'b1), .src_b(bus.id_rt), .use_b(bus.id_uses_rt),
    .hit(br_mem_hit)
  );

  // ---------------------------------------------------------------------------
  // Forwarding selects: EX/MEM result beats WB write data
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.forward_a = FWD_RF;
    if (fwd_a_mem)     bus.forward_a = FWD_MEM;
    else if (fwd_a_wb) bus.forward_a = FWD_WB;
  end

  always_comb begin
    bus.forward_b = FWD_RF;
    if (fwd_b_mem)     bus.forward_b = FWD_MEM;
    else if (fwd_b_wb) bus.forward_b = FWD_WB;
  end

  // ---------------------------------------------------------------------------
  // Data-memory freeze FSM
  // ---------------------------------------------------------------------------
  frz_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // MEM_WAIT ignores mem_access, so the access held in MEM while frozen
  // cannot start a second freeze.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_RUN: begin
        if (MULTI_CYCLE && bus.mem_access) begin
          state_d = ST_MEM_WAIT;
          wcnt_d  = WAIT_INIT;
        end
      end
      ST_MEM_WAIT: begin
        if (wcnt_q != '0) wcnt_d  = wcnt_q - WCNT_W'(1);
        else              state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    freeze = 1'b0;
    case (state_q)
      ST_RUN:      freeze = MULTI_CYCLE && bus.mem_access;
      ST_MEM_WAIT: freeze = (wcnt_q != '0);
      default:     freeze = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall / redirect arbitration and pipe-register controls
  // ---------------------------------------------------------------------------
  logic stall, take_redirect;

  always_comb begin
    stall = !freeze &&
            (load_use || (BR_IN_ID && bus.id_branch && (br_ex_hit || br_mem_hit)));
    // A redirect blocked by freeze/stall is re-presented because ID/EX hold.
    take_redirect = bus.redirect && !freeze && !stall;
  end

  always_comb begin
    bus.pc_enable     = 1'b1;
    bus.if_id_enable  = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_bubble  = 1'b0;
    bus.id_ex_enable  = 1'b1;
    bus.ex_mem_enable = 1'b1;
    bus.mem_wb_bubble = 1'b0;
    if (freeze) begin
      bus.pc_enable     = 1'b0;
      bus.if_id_enable  = 1'b0;
      bus.id_ex_enable  = 1'b0;
      bus.ex_mem_enable = 1'b0;
      bus.mem_wb_bubble = 1'b1;
    end else if (stall) begin
      bus.pc_enable    = 1'b0;
      bus.if_id_enable = 1'b0;
      bus.id_ex_bubble = 1'b1;
    end else if (take_redirect) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = !BR_IN_ID;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((freeze || stall) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (take_redirect && (flush_cnt_q != '1))     flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
